hqm_aw_rf_pg_seq: RTL

- Power-gate sequencer for one power-gated RF/SRAM macro, or a daisy-chain of them.
- Drives the macro-side controls: pwr_enable_b, isolation enable and ip_reset_b.
- Consumes the returned chain acknowledge.
- Gates functional access (mem_rdy) so the client never issues we/re to an unpowered, isolated or reset array.

---
 rtl/hqm_aw_rf_pg_seq_if.sv | 27 ++
 rtl/hqm_aw_rf_pg_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hqm_aw_rf_pg_seq_if.sv
// Handshake bundle between the power-gate sequencer, its client and the macro chain.
`default_nettype none

interface hqm_aw_rf_pg_seq_if;
  logic       pwr_req;
  logic       mem_busy;
  logic       pwr_enable_b_ack;
  logic       err_clr;
  logic       pwr_enable_b;
  logic       pgcb_isol_en;
  logic       ip_reset_b;
  logic       mem_rdy;
  logic [2:0] pwr_state;
  logic       timeout_err;

  modport master (
    output pwr_req, mem_busy, pwr_enable_b_ack, err_clr,
    input  pwr_enable_b, pgcb_isol_en, ip_reset_b, mem_rdy, pwr_state, timeout_err
  );

  modport slave (
    input  pwr_req, mem_busy, pwr_enable_b_ack, err_clr,
    output pwr_enable_b, pgcb_isol_en, ip_reset_b, mem_rdy, pwr_state, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/hqm_aw_rf_pg_seq.sv
// Power-gate sequencer for a power-gated RF/SRAM macro chain: orders power,
// isolation and reset edges and gates client access while the array is unsafe.
`default_nettype none

module hqm_aw_rf_pg_seq #(
  parameter int SETTLE_CYC  = 4,
  parameter int ISO_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hqm_aw_rf_pg_seq_if.slave     pg
);

  localparam int MAX_A   = (SETTLE_CYC > ISO_CYC) ? SETTLE_CYC : ISO_CYC;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LAST     = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_PU_ACK    = 3'd1;
  localparam logic [2:0] ST_PU_SETTLE = 3'd2;
  localparam logic [2:0] ST_PU_ISO    = 3'd3;
  localparam logic [2:0] ST_ON        = 3'd4;
  localparam logic [2:0] ST_PD_DRAIN  = 3'd5;
  localparam logic [2:0] ST_PD_ISO    = 3'd6;
  localparam logic [2:0] ST_PD_ACK    = 3'd7;

  if (SETTLE_CYC < 1 || ISO_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("hqm_aw_rf_pg_seq: SETTLE_CYC>=1, ISO_CYC>=1 and TIMEOUT_CYC>=2 required");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_err;
  logic             timeout_hit;

  // State, dwell counter and sticky error; a timeout set wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (pg.err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      ST_OFF: begin
        if (pg.pwr_req && !timeout_err) state_nxt = ST_PU_ACK;
      end
      ST_PU_ACK: begin
        if (!pg.pwr_enable_b_ack) begin
          state_nxt = ST_PU_SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = ST_OFF;
          timeout_hit = 1'b1;
        end
      end
      ST_PU_SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = ST_PU_ISO;
      end
      ST_PU_ISO: begin
        if (cnt == ISO_LAST) state_nxt = ST_ON;
      end
      ST_ON: begin
        if (!pg.pwr_req) state_nxt = ST_PD_DRAIN;
      end
      ST_PD_DRAIN: begin
        if (!pg.mem_busy) state_nxt = ST_PD_ISO;
      end
      ST_PD_ISO: begin
        if (cnt == ISO_LAST) state_nxt = ST_PD_ACK;
      end
      ST_PD_ACK: begin
        if (pg.pwr_enable_b_ack) begin
          state_nxt = ST_OFF;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = ST_OFF;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Macro controls decode from the state register only.
  always_comb begin
    pg.pwr_enable_b = 1'b1;
    pg.pgcb_isol_en = 1'b1;
    pg.ip_reset_b   = 1'b0;
    pg.mem_rdy      = 1'b0;
    case (state)
      ST_PU_ACK, ST_PU_SETTLE, ST_PD_ISO: begin
        pg.pwr_enable_b = 1'b0;
      end
      ST_PU_ISO: begin
        pg.pwr_enable_b = 1'b0;
        pg.pgcb_isol_en = 1'b0;
      end
      ST_ON: begin
        pg.pwr_enable_b = 1'b0;
        pg.pgcb_isol_en = 1'b0;
        pg.ip_reset_b   = 1'b1;
        pg.mem_rdy      = 1'b1;
      end
      ST_PD_DRAIN: begin
        pg.pwr_enable_b = 1'b0;
        pg.pgcb_isol_en = 1'b0;
        pg.ip_reset_b   = 1'b1;
      end
      default: begin
        pg.pwr_enable_b = 1'b1;
      end
    endcase
    pg.pwr_state   = state;
    pg.timeout_err = timeout_err;
  end

endmodule

`default_nettype wire
